// File: rtl/gcd_feeder.sv
`timescale 1ns/1ps
// gcd_feeder: buffers 8-bit operand pairs in a small FIFO and hands them one
// at a time to an external GCD core. Each job's result, or a timeout abort
// when the core never answers, is held in a valid/ready output register
// together with a 2-bit job sequence tag.
module gcd_feeder #(
    parameter int DEPTH   = 4,   // queued operand pairs, power of two, >= 2
    parameter int TIMEOUT = 255  // WAIT cycles allowed before the job is aborted
) (
    input  logic       clk,
    input  logic       rst,
    // upstream operand stream
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    // GCD core handshake
    output logic       gcd_start,
    output logic [7:0] gcd_a,
    output logic [7:0] gcd_b,
    input  logic       gcd_done,
    input  logic [7:0] gcd_y,
    input  logic       gcd_error,
    // downstream result stream
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_y,
    output logic       out_error,
    output logic       out_timeout,
    output logic [1:0] out_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // The counter only has to reach TIMEOUT-1: the cycle that would make it
    // TIMEOUT is the abort cycle itself.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    logic [1:0]    job_cnt_q, job_cnt_d;
    logic [1:0]    job_tag_q, job_tag_d;

    logic [7:0]    gcd_a_q, gcd_a_d;
    logic [7:0]    gcd_b_q, gcd_b_d;
    logic [7:0]    out_y_q, out_y_d;
    logic          out_error_q, out_error_d;
    logic          out_timeout_q, out_timeout_d;
    logic [1:0]    out_tag_q, out_tag_d;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens a slot for a push into a full FIFO.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // The head is popped on the IDLE->ISSUE edge, straight into gcd_a/gcd_b.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

    // FIFO storage: payload written on every accepted push.
    // NOTE: the storage array has no reset; the count and pointers define
    // which entries are live, so stale contents can never be observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FSM next state: one job in flight, from issue to downstream transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (count_q != '0)         state_d = S_ISSUE;
            S_ISSUE:                            state_d = S_WAIT;
            S_WAIT:  if (gcd_done || tmo_hit)   state_d = S_HOLD;
            S_HOLD:  if (out_ready)             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // FSM outputs: both strobes are pure decodes of the state register.
    always_comb begin
        gcd_start = (state_q == S_ISSUE);
        out_valid = (state_q == S_HOLD);
    end

    // Job datapath: operand load at issue, result or abort capture in WAIT.
    // NOTE: every variable gets its hold value first so that no path through
    // this block leaves one unassigned, which would infer a latch.
    always_comb begin
        gcd_a_d       = gcd_a_q;
        gcd_b_d       = gcd_b_q;
        tmo_d         = tmo_q;
        job_cnt_d     = job_cnt_q;
        job_tag_d     = job_tag_q;
        out_y_d       = out_y_q;
        out_error_d   = out_error_q;
        out_timeout_d = out_timeout_q;
        out_tag_d     = out_tag_q;

        if (pop) begin
            {gcd_a_d, gcd_b_d} = mem_q[rd_ptr_q];
            job_tag_d          = job_cnt_q;
            job_cnt_d          = job_cnt_q + 2'd1;
            tmo_d              = '0;
        end

        if (state_q == S_WAIT) begin
            if (gcd_done) begin
                // A completion in the abort cycle still counts as a completion.
                out_y_d       = gcd_y;
                out_error_d   = gcd_error;
                out_timeout_d = 1'b0;
                out_tag_d     = job_tag_q;
            end else if (tmo_hit) begin
                out_y_d       = 8'd0;
                out_error_d   = 1'b1;
                out_timeout_d = 1'b1;
                out_tag_d     = job_tag_q;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset; reset also drops
    // any queued or in-flight job.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            job_cnt_q     <= 2'd0;
            job_tag_q     <= 2'd0;
            gcd_a_q       <= 8'd0;
            gcd_b_q       <= 8'd0;
            out_y_q       <= 8'd0;
            out_error_q   <= 1'b0;
            out_timeout_q <= 1'b0;
            out_tag_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            job_cnt_q     <= job_cnt_d;
            job_tag_q     <= job_tag_d;
            gcd_a_q       <= gcd_a_d;
            gcd_b_q       <= gcd_b_d;
            out_y_q       <= out_y_d;
            out_error_q   <= out_error_d;
            out_timeout_q <= out_timeout_d;
            out_tag_q     <= out_tag_d;
        end
    end

    assign gcd_a       = gcd_a_q;
    assign gcd_b       = gcd_b_q;
    assign out_y       = out_y_q;
    assign out_error   = out_error_q;
    assign out_timeout = out_timeout_q;
    assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_gcd_feeder.sv
`timescale 1ns/1ps
// Testbench for gcd_feeder: a behavioural GCD core drives the core handshake,
// a scoreboard queue holds the expected result of every accepted pair, and a
// monitor compares each transferred result in order.
module tb_gcd_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       gcd_start;
    logic [7:0] gcd_a, gcd_b;
    logic       gcd_done;
    logic [7:0] gcd_y;
    logic       gcd_error;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_error;
    logic       out_timeout;
    logic [1:0] out_tag;

    gcd_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .gcd_start   (gcd_start),
        .gcd_a       (gcd_a),
        .gcd_b       (gcd_b),
        .gcd_done    (gcd_done),
        .gcd_y       (gcd_y),
        .gcd_error   (gcd_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_error   (out_error),
        .out_timeout (out_timeout),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       err;
        logic       tmo;
        logic [1:0] tag;
    } res_t;

    res_t       sb[$];
    logic [1:0] sb_tag;
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         results      = 0;

    // core model controls
    int         core_lat   = 5;
    bit         core_never = 1'b0;
    bit         core_hold  = 1'b0;
    bit         core_busy  = 1'b0;
    int         core_cnt   = 0;
    logic [7:0] core_a, core_b;

    // monitor state
    bit         in_flight = 1'b0;
    logic [7:0] flight_a, flight_b;
    bit         hold_seen = 1'b0;
    res_t       hold_prev;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural GCD core: latches operands on start, answers core_lat cycles later.
    always @(negedge clk) begin
        if (gcd_start === 1'b1) begin
            core_busy = 1'b1;
            core_cnt  = 0;
            core_a    = gcd_a;
            core_b    = gcd_b;
            gcd_done  = 1'b0;
            gcd_y     = 8'hA5;
            gcd_error = 1'b1;
        end else begin
            if (!core_hold) begin
                gcd_done  = 1'b0;
                gcd_y     = 8'hA5;
                gcd_error = 1'b1;
            end
            if (core_busy) begin
                core_cnt++;
                if (!core_never && core_cnt == core_lat) begin
                    gcd_done  = 1'b1;
                    gcd_y     = ref_gcd(core_a, core_b);
                    gcd_error = (core_a == 8'd0) && (core_b == 8'd0);
                    core_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: single job in flight, stable operands, stable HOLD, in-order results.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (gcd_start === 1'b1) begin
                tests_run++;
                if (in_flight) begin
                    tests_failed++;
                    $display("FAIL start_overlap: gcd_start=1 while a job is in flight, required 0");
                end
                in_flight = 1'b1;
                flight_a  = gcd_a;
                flight_b  = gcd_b;
            end else if (in_flight) begin
                tests_run++;
                if (gcd_a !== flight_a || gcd_b !== flight_b) begin
                    tests_failed++;
                    $display("FAIL operand_stable: gcd_a/b=%0d/%0d, required %0d/%0d",
                             gcd_a, gcd_b, flight_a, flight_b);
                end
            end

            if (out_valid === 1'b1) begin
                if (hold_seen) begin
                    tests_run++;
                    if ({out_y, out_error, out_timeout, out_tag} !== hold_prev) begin
                        tests_failed++;
                        $display("FAIL hold_stable: out=%h, required %h",
                                 {out_y, out_error, out_timeout, out_tag}, hold_prev);
                    end
                end
                if (out_ready === 1'b1) begin
                    res_t exp;
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_result: y=%0d err=%0b tmo=%0b tag=%0d, required no result",
                                 out_y, out_error, out_timeout, out_tag);
                    end else begin
                        exp = sb.pop_front();
                        if ({out_y, out_error, out_timeout, out_tag} !== exp) begin
                            tests_failed++;
                            $display("FAIL result: y=%0d err=%0b tmo=%0b tag=%0d, required y=%0d err=%0b tmo=%0b tag=%0d",
                                     out_y, out_error, out_timeout, out_tag,
                                     exp.y, exp.err, exp.tmo, exp.tag);
                        end
                    end
                    results++;
                    in_flight = 1'b0;
                    hold_seen = 1'b0;
                end else begin
                    hold_seen = 1'b1;
                    hold_prev = {out_y, out_error, out_timeout, out_tag};
                end
            end else begin
                hold_seen = 1'b0;
            end
        end
    end

    // Offer one pair and wait (bounded) until it is accepted; record its expected result.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        res_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 600; i++) begin
            if (in_ready === 1'b1) begin
                if (core_never || core_lat > TIMEOUT) begin
                    e.y = 8'd0; e.err = 1'b1; e.tmo = 1'b1;
                end else begin
                    e.y = ref_gcd(a, b); e.err = (a == 8'd0) && (b == 8'd0); e.tmo = 1'b0;
                end
                e.tag  = sb_tag;
                sb_tag = sb_tag + 2'd1;
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        tests_failed++;
        $display("FAIL push_wait: in_ready stayed 0 for pair %0d/%0d, required 1", a, b);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_valid: out_valid=%b, required 1", name, out_valid);
        end
    endtask

    task automatic flush_model();
        sb.delete();
        sb_tag    = 2'd0;
        in_flight = 1'b0;
        hold_seen = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if ({in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_error, out_timeout, out_tag}
            !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL %s_outputs: rdy=%b st=%b a=%0d b=%0d v=%b y=%0d e=%b t=%b tag=%0d, required rdy=1 and all others 0",
                     name, in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_error, out_timeout, out_tag);
        end
    endtask

    // Reset with a push offered in the reset cycles; nothing may come of it.
    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'h11;
        in_b     = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        flush_model();
        check_idle_outputs("reset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (gcd_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_push_discarded: gcd_start=%b in cycle %0d, required 0", gcd_start, i);
            end
        end
    endtask

    // Single job: start latency c+2, one-cycle start pulse, registered operands.
    task automatic test_basic();
        out_ready = 1'b1;
        core_lat  = 5;
        push_pair(8'd21, 8'd6);
        tests_run++;
        if (gcd_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_start_early: gcd_start=%b in c+1, required 0", gcd_start);
        end
        @(posedge clk); #1;
        tests_run++;
        if (gcd_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_start_latency: gcd_start=%b in c+2, required 1", gcd_start);
        end
        tests_run++;
        if ({gcd_a, gcd_b} !== {8'd21, 8'd6}) begin
            tests_failed++;
            $display("FAIL basic_operands: gcd_a/b=%0d/%0d, required 21/6", gcd_a, gcd_b);
        end
        @(posedge clk); #1;
        tests_run++;
        if (gcd_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_start_width: gcd_start=%b in c+3, required 0", gcd_start);
        end
        drain("basic");
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_back_to_idle: out_valid=%b, required 0", out_valid);
        end
    endtask

    // Three pairs back to back, the middle one makes the core flag an error.
    task automatic test_back_to_back();
        int r0;
        r0        = results;
        out_ready = 1'b1;
        core_lat  = 3;
        push_pair(8'd24, 8'd0);
        push_pair(8'd0,  8'd0);
        push_pair(8'd0,  8'd6);
        drain("back_to_back");
        tests_run++;
        if (results - r0 != 3) begin
            tests_failed++;
            $display("FAIL back_to_back_count: %0d results, required 3", results - r0);
        end
    endtask

    // Backpressure: 1 in flight + DEPTH queued, then full until one transfer.
    task automatic test_full();
        out_ready = 1'b0;
        core_lat  = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_pair(8'(10 + 5 * i), 8'(15 + 5 * i));
        end
        in_valid = 1'b1;
        in_a     = 8'd99;
        in_b     = 8'd33;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_in_ready: in_ready=%b with %0d queued, required 0", in_ready, DEPTH);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid("full");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_pair(8'd99, 8'd33);
        out_ready = 1'b1;
        drain("full");
    endtask

    // Core never answers: abort exactly TIMEOUT cycles after WAIT entry.
    task automatic test_timeout();
        int n;
        out_ready  = 1'b1;
        core_never = 1'b1;
        push_pair(8'd40, 8'd15);
        n = 0;
        while (gcd_start !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (gcd_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_issue: gcd_start=%b, required 1", gcd_start);
        end else begin
            n = 0;
            while (out_valid !== 1'b1 && n < TIMEOUT + 20) begin
                @(posedge clk); #1;
                n++;
            end
            tests_run++;
            if (n != TIMEOUT + 1) begin
                tests_failed++;
                $display("FAIL timeout_latency: out_valid %0d cycles after issue, required %0d", n, TIMEOUT + 1);
            end
        end
        drain("timeout");
        core_never = 1'b0;
        core_lat   = 3;
        push_pair(8'd40, 8'd15);
        drain("after_timeout");
    endtask

    // Done held high as a level through HOLD and IDLE: one result per issue.
    task automatic test_done_level();
        int  r0;
        bit  extra;
        r0        = results;
        core_hold = 1'b1;
        core_lat  = 4;
        out_ready = 1'b0;
        push_pair(8'd9,  8'd6);
        push_pair(8'd14, 8'd21);
        wait_valid("done_level");
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("done_level");
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || gcd_start !== 1'b0) extra = 1'b1;
        end
        tests_run++;
        if (extra) begin
            tests_failed++;
            $display("FAIL done_level_idle: activity seen in IDLE with done held, required none");
        end
        tests_run++;
        if (results - r0 != 2) begin
            tests_failed++;
            $display("FAIL done_level_count: %0d results, required 2", results - r0);
        end
        core_hold = 1'b0;
    endtask

    // Done in the abort cycle wins; done one cycle later is a timeout.
    task automatic test_done_timeout_tie();
        out_ready = 1'b1;
        core_lat  = TIMEOUT;
        push_pair(8'd48, 8'd18);
        drain("tie_done");
        core_lat  = TIMEOUT + 1;
        push_pair(8'd30, 8'd12);
        drain("tie_late");
    endtask

    // One-cycle reset during WAIT with two queued jobs; late done is ignored.
    task automatic test_reset_mid_job();
        bit seen;
        out_ready = 1'b1;
        core_lat  = 20;
        push_pair(8'd35, 8'd14);
        push_pair(8'd50, 8'd20);
        push_pair(8'd60, 8'd45);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush_model();
        check_idle_outputs("reset_mid_job");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || gcd_start !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL reset_mid_job_quiet: out_valid or gcd_start seen after reset, required none");
        end
        check_idle_outputs("reset_mid_job_late");
        core_lat = 3;
        push_pair(8'd8, 8'd12);
        drain("after_reset");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
        gcd_done  = 1'b0;
        gcd_y     = 8'd0;
        gcd_error = 1'b0;
        sb_tag    = 2'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_timeout();
        test_done_level();
        test_done_timeout_tie();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gcd_feeder.md
GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 Parameter DEPTH, 4, operand-pair FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, 255, max cycles in WAIT before the job is aborted.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 IN_VALID  in  1  upstream offers an operand pair.
REQ-006 IN_READY  out  1  FIFO can accept; equals !full from the registered count.
REQ-007 IN_A, IN_B  in  8 each  operands.
REQ-008 GCD_START  out  1  one-cycle start pulse to the GCD core.
REQ-009 GCD_A, GCD_B  out  8 each  operands to the core, registered.
REQ-010 GCD_DONE  in  1  core completion, treated as a level.
REQ-011 GCD_Y  in  8  core result.
REQ-012 GCD_ERROR  in  1  core error flag.
REQ-013 OUT_VALID  out  1  result available.
REQ-014 OUT_READY  in  1  downstream accepts the result.
REQ-015 OUT_Y  out  8  captured result.
REQ-016 OUT_ERROR  out  1  captured error, or timeout.
REQ-017 OUT_TIMEOUT  out  1  result produced by timeout abort.
REQ-018 OUT_TAG  out  2  job sequence number.

Function
REQ-019 Push occurs when IN_VALID && IN_READY; FIFO is first-in first-out; a push while full is impossible, because IN_READY is 0 even if a pop happens in the same cycle.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD; only one job is in flight.
REQ-021 IDLE: if FIFO count != 0, go to ISSUE next edge; else stay.
REQ-022 Entering ISSUE: pop FIFO head into GCD_A/GCD_B; GCD_START=1 for exactly the ISSUE cycle; go to WAIT; timeout counter cleared.
REQ-023 GCD_A/GCD_B SHALL hold stable from ISSUE until the next ISSUE.
REQ-024 Push into an empty idle block in cycle c SHALL give GCD_START=1 in cycle c+2.
REQ-025 WAIT: the first cycle with GCD_DONE=1 captures GCD_Y->OUT_Y, GCD_ERROR->OUT_ERROR, OUT_TIMEOUT=0; go to HOLD.
REQ-026 GCD_DONE is sampled in WAIT only, including the ISSUE+1 cycle; GCD_DONE in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-027 WAIT: the counter increments each cycle without GCD_DONE; on reaching TIMEOUT, OUT_Y=0, OUT_ERROR=1, OUT_TIMEOUT=1; go to HOLD.
REQ-028 If GCD_DONE and the counter reaching TIMEOUT occur in the same cycle, DONE wins.
REQ-029 HOLD: OUT_VALID=1 with OUT_Y/OUT_ERROR/OUT_TIMEOUT/OUT_TAG stable; on OUT_READY=1, transfer, go to IDLE; OUT_VALID=0 next cycle.
REQ-030 OUT_VALID SHALL never be 1 outside HOLD; OUT_READY outside HOLD SHALL be ignored.
REQ-031 OUT_TAG equals the job counter value at ISSUE; the counter increments once per ISSUE and wraps 3->0.
REQ-032 The FIFO SHALL continue accepting pushes in every FSM state, including HOLD with OUT_READY=0.
REQ-033 Capacity is DEPTH queued jobs plus one in flight.

Reset
REQ-034 With RST=1 at an edge: FSM=IDLE; FIFO empty; job counter=0; timeout counter=0; all registered outputs 0 (GCD_START, GCD_A, GCD_B, OUT_VALID, OUT_Y, OUT_ERROR, OUT_TIMEOUT, OUT_TAG).
REQ-035 Pushes in a reset cycle SHALL be discarded; IN_READY reflects the empty FIFO (1) after the reset edge.
REQ-036 Reset mid-job (ISSUE/WAIT/HOLD) abandons the job and flushes the FIFO; a GCD_DONE arriving afterwards SHALL be ignored.

Verification
REQ-037 Push (21,6); core model returns Y=3 after 5 cycles; OUT_READY=1 -> GCD_START in cycle c+2, OUT_VALID=1 with OUT_Y=3, OUT_ERROR=0, OUT_TAG=0, then IDLE.
REQ-038 Push (24,0),(0,0),(0,6) back-to-back; model errors on (0,0) -> three results in order with tags 1,2,3; only the second has OUT_ERROR=1; no GCD_START while a job is in WAIT/HOLD.
REQ-039 Hold OUT_READY=0, push 6 pairs -> 5 accepted (1 in flight + 4 queued); IN_READY=0 on the 6th; after one OUT_READY pulse the 6th is accepted; tag wraps 3->0 on the 5th job.
REQ-040 Model never asserts DONE -> OUT_VALID exactly TIMEOUT cycles after WAIT entry, with OUT_Y=0, OUT_ERROR=1, OUT_TIMEOUT=1; the next job proceeds normally.
REQ-041 RST=1 for 1 cycle during WAIT with 2 queued jobs; model asserts DONE afterwards -> no OUT_VALID, FIFO empty, OUT_TAG=0, all outputs 0.
REQ-042 DONE held high through HOLD and IDLE -> exactly one result per ISSUE; DONE and timeout in the same cycle -> OUT_TIMEOUT=0, OUT_Y=GCD_Y.
